contrast_lut_ctrl: RTL and testbench

- Runtime-reprogrammable contrast lookup stage for the 8-bit video AXI-Stream path. Supersedes the fixed, elaboration-time contrast table.
- Owns a double-buffered LUT: host writes the shadow bank while the active bank maps pixels.
- A host commit swaps the banks atomically at the next start-of-frame (tuser), so no frame is ever mapped by a mixed table.
- Sits between the sensor-side stream and downstream processing. Full AXI-Stream backpressure, 1-cycle latency.

---
 rtl/contrast_lut_ctrl_pkg.sv | 27 ++
 rtl/contrast_lut_ctrl_if.sv | 20 ++
 rtl/contrast_lut_ctrl_lut_bank_ram.sv | 42 ++++
 rtl/contrast_lut_ctrl.sv | 146 ++++++++++++++
 tb/tb_contrast_lut_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/contrast_lut_ctrl_pkg.sv
// Shared definitions for the contrast LUT stage.
//   DATA_WIDTH_DEF : default pixel / LUT address / LUT data width
//   LUT_DEPTH      : entries per LUT bank (2**DATA_WIDTH_DEF)
//   lut_state_e    : bank-swap controller states
//   lut_t          : full contents of one LUT bank
//   identity_lut() : power-up contents of a bank (entry i = i)
package contrast_lut_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned LUT_DEPTH      = 2 ** DATA_WIDTH_DEF;

  typedef enum logic [0:0] {
    IDLE,
    PENDING
  } lut_state_e;

  typedef logic [LUT_DEPTH-1:0][DATA_WIDTH_DEF-1:0] lut_t;

  function automatic lut_t identity_lut();
    lut_t lut;
    for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
      lut[i] = DATA_WIDTH_DEF'(i);
    end
    return lut;
  endfunction

endpackage

// File: rtl/contrast_lut_ctrl_if.sv
// AXI-Stream video beat bundle (no tkeep/tstrb).
//   tvalid/tready : handshake
//   tdata         : pixel
//   tuser         : start of frame
//   tlast         : end of line
// master drives the beat and samples tready; slave is the mirror.
interface contrast_lut_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tuser;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);

endinterface

// File: rtl/contrast_lut_ctrl_lut_bank_ram.sv
// One LUT bank: single write port (host) and single synchronous read port (pixel path).
//   clk, rst_n            : clock, async active-low reset (read register only)
//   i_wr_en/addr/data     : host write port
//   i_rd_en, i_rd_addr    : read request; data appears in o_rd_data next cycle
//   o_rd_data             : registered read data, held while i_rd_en is low
// The array powers up as identity and is never touched by reset.
module contrast_lut_ctrl_lut_bank_ram
  import contrast_lut_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  lut_t                  r_mem = identity_lut();
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register doubles as the output pixel register, so it carries the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/contrast_lut_ctrl.sv
// Runtime-reprogrammable contrast LUT on an 8-bit AXI-Stream video path.
//   clk, rst_n        : clock, async active-low reset
//   s_axis            : input pixels (tuser = SOF, tlast = EOL)
//   m_axis            : mapped pixels, 1-cycle latency, tuser/tlast forwarded
//   i_cfg_wr_en/addr/data : host write into the shadow bank
//   o_cfg_wr_ready    : shadow writes accepted (IDLE only)
//   i_cfg_commit      : request a bank swap at the next SOF handshake
//   o_cfg_pending     : commit accepted, swap not yet taken
//   o_cfg_active_bank : bank currently mapping pixels
//   o_cfg_swap_done   : one-cycle pulse in the cycle after a swap
module contrast_lut_ctrl
  import contrast_lut_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  contrast_lut_ctrl_if.slave     s_axis,
  contrast_lut_ctrl_if.master    m_axis,
  input  logic                   i_cfg_wr_en,
  input  logic [DATA_WIDTH-1:0]  i_cfg_wr_addr,
  input  logic [DATA_WIDTH-1:0]  i_cfg_wr_data,
  output logic                   o_cfg_wr_ready,
  input  logic                   i_cfg_commit,
  output logic                   o_cfg_pending,
  output logic                   o_cfg_active_bank,
  output logic                   o_cfg_swap_done
);

  lut_state_e            r_state;
  logic                  r_active;
  logic                  r_pending;
  logic                  r_wr_ready;
  logic                  r_swap_done;
  logic                  r_tvalid;
  logic                  r_tuser;
  logic                  r_tlast;
  logic                  r_rd_sel;

  logic                  w_s_ready;
  logic                  w_s_hs;
  logic                  w_swap;
  logic                  w_rd_sel;
  logic                  w_wr_en;
  logic                  w_wr_en0;
  logic                  w_wr_en1;
  logic [DATA_WIDTH-1:0] w_rd_data0;
  logic [DATA_WIDTH-1:0] w_rd_data1;

  assign w_s_ready = !r_tvalid || m_axis.tready;
  assign w_s_hs    = s_axis.tvalid && w_s_ready;
  assign w_swap    = (r_state == PENDING) && w_s_hs && s_axis.tuser;
  // The SOF beat that triggers the swap is already mapped by the new table.
  assign w_rd_sel  = w_swap ? ~r_active : r_active;

  // Host writes always target the shadow bank and are dropped while a swap is pending.
  assign w_wr_en  = i_cfg_wr_en && (r_state == IDLE);
  assign w_wr_en0 = w_wr_en && r_active;
  assign w_wr_en1 = w_wr_en && !r_active;

  contrast_lut_ctrl_lut_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en0),
    .i_wr_addr (i_cfg_wr_addr),
    .i_wr_data (i_cfg_wr_data),
    .i_rd_en   (w_s_hs),
    .i_rd_addr (s_axis.tdata),
    .o_rd_data (w_rd_data0)
  );

  contrast_lut_ctrl_lut_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en1),
    .i_wr_addr (i_cfg_wr_addr),
    .i_wr_data (i_cfg_wr_data),
    .i_rd_en   (w_s_hs),
    .i_rd_addr (s_axis.tdata),
    .o_rd_data (w_rd_data1)
  );

  // Output beat control; data lives in the bank read registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid <= 1'b0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
      r_rd_sel <= 1'b0;
    end else if (w_s_hs) begin
      r_tvalid <= 1'b1;
      r_tuser  <= s_axis.tuser;
      r_tlast  <= s_axis.tlast;
      r_rd_sel <= w_rd_sel;
    end else if (m_axis.tready) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_active    <= 1'b0;
      r_pending   <= 1'b0;
      r_wr_ready  <= 1'b1;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_cfg_commit) begin
            r_state    <= PENDING;
            r_pending  <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        PENDING: begin
          // Further commits are ignored here; only an SOF handshake moves on.
          if (w_swap) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_wr_ready  <= 1'b1;
            r_active    <= ~r_active;
            r_swap_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axis.tready     = w_s_ready;
  assign m_axis.tvalid     = r_tvalid;
  assign m_axis.tdata      = r_rd_sel ? w_rd_data1 : w_rd_data0;
  assign m_axis.tuser      = r_tuser;
  assign m_axis.tlast      = r_tlast;
  assign o_cfg_wr_ready    = r_wr_ready;
  assign o_cfg_pending     = r_pending;
  assign o_cfg_active_bank = r_active;
  assign o_cfg_swap_done   = r_swap_done;

endmodule

// File: tb/tb_contrast_lut_ctrl.sv
// Directed bench for contrast_lut_ctrl: bank swaps, backpressure, pending writes, reset.
module tb_contrast_lut_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_cfg_wr_en;
  logic [7:0] i_cfg_wr_addr;
  logic [7:0] i_cfg_wr_data;
  logic       o_cfg_wr_ready;
  logic       i_cfg_commit;
  logic       o_cfg_pending;
  logic       o_cfg_active_bank;
  logic       o_cfg_swap_done;

  int n_checks;
  int n_errors;
  int swap_cnt;

  logic [9:0] expq[$];  // {tdata, tuser, tlast}
  logic [9:0] mon_exp;

  contrast_lut_ctrl_if #(.DATA_WIDTH(8)) s_if ();
  contrast_lut_ctrl_if #(.DATA_WIDTH(8)) m_if ();

  contrast_lut_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .i_cfg_wr_en       (i_cfg_wr_en),
    .i_cfg_wr_addr     (i_cfg_wr_addr),
    .i_cfg_wr_data     (i_cfg_wr_data),
    .o_cfg_wr_ready    (o_cfg_wr_ready),
    .i_cfg_commit      (i_cfg_commit),
    .o_cfg_pending     (o_cfg_pending),
    .o_cfg_active_bank (o_cfg_active_bank),
    .o_cfg_swap_done   (o_cfg_swap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: every delivered beat must match the next expected beat in order.
  always @(negedge clk) begin
    if (m_if.tvalid && m_if.tready) begin
      check("out_beat_expected", 32'(expq.size() != 0), 1);
      if (expq.size() != 0) begin
        mon_exp = expq.pop_front();
        check("out_beat", {22'd0, m_if.tdata, m_if.tuser, m_if.tlast}, {22'd0, mon_exp});
      end
    end
    if (o_cfg_swap_done) swap_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and return #1 after the edge on which it was accepted.
  task automatic drive_beat(input logic [7:0] d, input logic u, input logic l,
                            input logic [7:0] e);
    int   n;
    logic hs;
    expq.push_back({e, u, l});
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    n = 0;
    do begin
      @(negedge clk);
      hs = s_if.tready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 50);
    check("beat_accepted", 32'(hs), 1);
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] e);
    check({tag, "_tvalid"}, 32'(m_if.tvalid), 1);
    check({tag, "_tdata"}, 32'(m_if.tdata), 32'(e));
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
    i_cfg_wr_en   = 1'b1;
    i_cfg_wr_addr = a;
    i_cfg_wr_data = d;
    idle(1);
    i_cfg_wr_en   = 1'b0;
  endtask

  task automatic commit_pulse();
    i_cfg_commit = 1'b1;
    idle(1);
    i_cfg_commit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    swap_cnt      = 0;
    rst_n         = 1'b1;
    s_if.tvalid   = 1'b0;
    s_if.tdata    = 8'd0;
    s_if.tuser    = 1'b0;
    s_if.tlast    = 1'b0;
    m_if.tready   = 1'b1;
    i_cfg_wr_en   = 1'b0;
    i_cfg_wr_addr = 8'd0;
    i_cfg_wr_data = 8'd0;
    i_cfg_commit  = 1'b0;
    #1 rst_n = 1'b0;
    #22;
    // Reset state
    check("rst_tvalid", 32'(m_if.tvalid), 0);
    check("rst_tdata", 32'(m_if.tdata), 0);
    check("rst_tuser", 32'(m_if.tuser), 0);
    check("rst_tlast", 32'(m_if.tlast), 0);
    check("rst_active", 32'(o_cfg_active_bank), 0);
    check("rst_pending", 32'(o_cfg_pending), 0);
    check("rst_swap_done", 32'(o_cfg_swap_done), 0);
    check("rst_wr_ready", 32'(o_cfg_wr_ready), 1);
    check("rst_s_tready", 32'(s_if.tready), 1);
    rst_n = 1'b1;
    idle(2);

    // 1: identity tables, one-cycle latency
    drive_beat(8'd0, 1'b1, 1'b0, 8'd0);
    expect_out("t1_p0", 8'd0);
    check("t1_p0_tuser", 32'(m_if.tuser), 1);
    drive_beat(8'd7, 1'b0, 1'b0, 8'd7);
    expect_out("t1_p7", 8'd7);
    drive_beat(8'd200, 1'b0, 1'b0, 8'd200);
    expect_out("t1_p200", 8'd200);
    drive_beat(8'd255, 1'b0, 1'b1, 8'd255);
    expect_out("t1_p255", 8'd255);
    check("t1_p255_tlast", 32'(m_if.tlast), 1);
    idle(2);
    check("t1_drained", 32'(expq.size()), 0);

    // 2: program inverse table in bank 1, commit mid-frame, swap at next SOF
    for (int i = 0; i < 256; i++) cfg_write(8'(i), 8'(255 - i));
    drive_beat(8'd5, 1'b1, 1'b0, 8'd5);
    drive_beat(8'd6, 1'b0, 1'b0, 8'd6);
    commit_pulse();
    check("t2_pending", 32'(o_cfg_pending), 1);
    check("t2_wr_ready", 32'(o_cfg_wr_ready), 0);
    drive_beat(8'd20, 1'b0, 1'b0, 8'd20);
    drive_beat(8'd30, 1'b0, 1'b1, 8'd30);
    check("t2_active_before", 32'(o_cfg_active_bank), 0);
    drive_beat(8'd10, 1'b1, 1'b0, 8'd245);
    expect_out("t2_sof", 8'd245);
    check("t2_active_after", 32'(o_cfg_active_bank), 1);
    check("t2_swap_done", 32'(o_cfg_swap_done), 1);
    check("t2_pending_clr", 32'(o_cfg_pending), 0);
    check("t2_wr_ready_back", 32'(o_cfg_wr_ready), 1);
    idle(1);
    check("t2_swap_done_clr", 32'(o_cfg_swap_done), 0);
    check("t2_swap_cnt", 32'(swap_cnt), 1);

    // 3: backpressure mid-line through the inverse table
    drive_beat(8'd1, 1'b0, 1'b0, 8'd254);
    fork
      begin
        drive_beat(8'd2, 1'b0, 1'b0, 8'd253);
        drive_beat(8'd3, 1'b0, 1'b0, 8'd252);
        drive_beat(8'd4, 1'b0, 1'b1, 8'd251);
      end
      begin
        m_if.tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("t3_s_tready_low", 32'(s_if.tready), 0);
          check("t3_hold_tvalid", 32'(m_if.tvalid), 1);
          check("t3_hold_tdata", 32'(m_if.tdata), 254);
        end
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
      end
    join
    idle(2);
    check("t3_drained", 32'(expq.size()), 0);

    // 4: writes ignored while pending; bank 0 entry 3 stays identity
    commit_pulse();
    check("t4_pending", 32'(o_cfg_pending), 1);
    check("t4_wr_ready", 32'(o_cfg_wr_ready), 0);
    cfg_write(8'd3, 8'd99);
    drive_beat(8'd3, 1'b1, 1'b0, 8'd3);
    expect_out("t4_entry3", 8'd3);
    check("t4_active", 32'(o_cfg_active_bank), 0);
    drive_beat(8'd100, 1'b0, 1'b1, 8'd100);
    idle(2);

    // 5: commit coinciding with an SOF handshake, then a redundant commit
    check("t5_s_tready", 32'(s_if.tready), 1);
    i_cfg_commit = 1'b1;
    drive_beat(8'd50, 1'b1, 1'b0, 8'd50);
    i_cfg_commit = 1'b0;
    check("t5_pending", 32'(o_cfg_pending), 1);
    check("t5_active_same", 32'(o_cfg_active_bank), 0);
    drive_beat(8'd60, 1'b0, 1'b1, 8'd60);
    commit_pulse();
    check("t5_pending2", 32'(o_cfg_pending), 1);
    drive_beat(8'd10, 1'b1, 1'b0, 8'd245);
    check("t5_active_swap", 32'(o_cfg_active_bank), 1);
    check("t5_pending_clr", 32'(o_cfg_pending), 0);
    drive_beat(8'd12, 1'b1, 1'b1, 8'd243);
    check("t5_no_extra_active", 32'(o_cfg_active_bank), 1);
    check("t5_no_extra_pending", 32'(o_cfg_pending), 0);
    idle(2);
    check("t5_swap_cnt", 32'(swap_cnt), 3);

    // 6: reset while pending, with an output beat held by backpressure
    commit_pulse();
    check("t6_pending", 32'(o_cfg_pending), 1);
    m_if.tready = 1'b0;
    drive_beat(8'd70, 1'b0, 1'b0, 8'd185);
    rst_n = 1'b0;
    #2;
    check("t6_rst_pending", 32'(o_cfg_pending), 0);
    check("t6_rst_active", 32'(o_cfg_active_bank), 0);
    check("t6_rst_tvalid", 32'(m_if.tvalid), 0);
    check("t6_rst_wr_ready", 32'(o_cfg_wr_ready), 1);
    expq.delete();
    #2 rst_n = 1'b1;
    idle(1);
    m_if.tready = 1'b1;
    drive_beat(8'd10, 1'b1, 1'b0, 8'd10);
    expect_out("t6_bank0", 8'd10);
    // Bank 1 contents survive reset
    commit_pulse();
    drive_beat(8'd10, 1'b1, 1'b0, 8'd245);
    expect_out("t6_bank1_kept", 8'd245);
    check("t6_active", 32'(o_cfg_active_bank), 1);
    idle(2);
    check("final_drained", 32'(expq.size()), 0);
    check("final_swap_cnt", 32'(swap_cnt), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
